// File: rtl/life_gen_sequencer.sv
// life_gen_sequencer
// Generation-level scheduler for the Game of Life engine. It walks the cell
// memory row by row and streams a toroidal three-row window into the cell
// array. For each row it strobes the array's compute phase and writes the
// result row into the opposite bank. Banks flip at the end of each generation.
// All outputs are decoded from registered state only.

module life_gen_sequencer #(
  parameter int ROWS  = 16,
  parameter int ROW_W = 4,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             stop,
  output logic             rd_en,
  output logic [ROW_W:0]   rd_addr,
  output logic             shift_en,
  output logic             run,
  output logic             wr_en,
  output logic [ROW_W:0]   wr_addr,
  output logic             busy,
  output logic             gen_done,
  output logic             bank,
  output logic [GEN_W-1:0] gen_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_P0,
    S_P1,
    S_P2,
    S_RD,
    S_SH,
    S_RUN,
    S_WR,
    S_END
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t             state_reg, state_next;
  logic [ROW_W-1:0]   row_reg, row_next;
  logic               bank_reg, bank_next;
  logic [GEN_W-1:0]   gen_count_reg, gen_count_next;
  logic               cont_reg, cont_next;
  logic               stop_pend_reg, stop_pend_next;

  // Row index of the next row, wrapping at ROWS rather than at 2^ROW_W.
  logic [ROW_W-1:0]   row_plus1;
  // Row presented on the read address while rd_en is high.
  logic [ROW_W-1:0]   rd_row;

  assign row_plus1 = (row_reg == LAST_ROW) ? '0 : row_reg + 1'b1;

  // State and bookkeeping registers; reset abandons any generation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      row_reg       <= '0;
      bank_reg      <= 1'b0;
      gen_count_reg <= '0;
      cont_reg      <= 1'b0;
      stop_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      row_reg       <= row_next;
      bank_reg      <= bank_next;
      gen_count_reg <= gen_count_next;
      cont_reg      <= cont_next;
      stop_pend_reg <= stop_pend_next;
    end
  end

  // Next-state logic and per-state strobe decode.
  always_comb begin
    state_next     = state_reg;
    row_next       = row_reg;
    bank_next      = bank_reg;
    gen_count_next = gen_count_reg;
    cont_next      = cont_reg;
    stop_pend_next = stop_pend_reg;
    rd_en          = 1'b0;
    rd_row         = '0;
    shift_en       = 1'b0;
    run            = 1'b0;
    wr_en          = 1'b0;

    // A stop while busy is remembered until the generation boundary.
    if (state_reg != S_IDLE && stop) begin
      stop_pend_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (start || step) begin
          state_next     = S_P0;
          cont_next      = start;
          stop_pend_next = stop;
          row_next       = '0;
        end
      end
      S_P0: begin
        // Prime the window with the row above row 0 (toroidal wrap).
        rd_en      = 1'b1;
        rd_row     = LAST_ROW;
        state_next = S_P1;
      end
      S_P1: begin
        shift_en   = 1'b1;
        rd_en      = 1'b1;
        rd_row     = '0;
        state_next = S_P2;
      end
      S_P2: begin
        shift_en   = 1'b1;
        row_next   = '0;
        state_next = S_RD;
      end
      S_RD: begin
        // Fetch the row below the current one.
        rd_en      = 1'b1;
        rd_row     = row_plus1;
        state_next = S_SH;
      end
      S_SH: begin
        shift_en   = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        run        = 1'b1;
        state_next = S_WR;
      end
      S_WR: begin
        wr_en = 1'b1;
        if (row_reg == LAST_ROW) begin
          state_next = S_END;
        end else begin
          row_next   = row_plus1;
          state_next = S_RD;
        end
      end
      S_END: begin
        bank_next      = ~bank_reg;
        gen_count_next = gen_count_reg + 1'b1;
        if (cont_reg && !stop_pend_reg && !stop) begin
          state_next = S_P0;
        end else begin
          state_next     = S_IDLE;
          cont_next      = 1'b0;
          stop_pend_next = 1'b0;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign rd_addr   = {bank_reg, rd_row};
  assign wr_addr   = {~bank_reg, row_reg};
  assign busy      = (state_reg != S_IDLE);
  assign gen_done  = (state_reg == S_END);
  assign bank      = bank_reg;
  assign gen_count = gen_count_reg;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Testbench for life_gen_sequencer: two instances (16-row and 3-row grids).
// A reference model expands each requested generation into its expected
// cycle-by-cycle strobe stream and queues it; a per-instance monitor pops
// one entry for every busy cycle and checks idle cycles against the bank
// and generation count left by the last completed generation.

module tb_life_gen_sequencer;

  typedef struct packed {
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic        shift_en;
    logic        run;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        gen_done;
    logic        busy;
    logic        bank;
    logic [15:0] cnt;
  } rec_t;

  logic clk;
  logic rst_s   [2];
  logic start_s [2];
  logic step_s  [2];
  logic stop_s  [2];

  rec_t        exp_q [2][$];
  logic        m_bank [2];
  logic [15:0] m_cnt  [2];

  int checks;
  int errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int rows_of(input int u);
    return (u == 0) ? 16 : 3;
  endfunction

  // Expand one generation into its expected per-cycle output stream.
  function automatic void push_gen(input int u);
    int   r;
    rec_t b;
    rec_t e;
    r = rows_of(u);
    b = '0;
    b.busy = 1'b1;
    b.bank = m_bank[u];
    b.cnt  = m_cnt[u];
    e = b; e.rd_en = 1'b1; e.rd_addr = {m_bank[u], 4'(r - 1)}; exp_q[u].push_back(e);
    e = b; e.rd_en = 1'b1; e.shift_en = 1'b1; e.rd_addr = {m_bank[u], 4'd0}; exp_q[u].push_back(e);
    e = b; e.shift_en = 1'b1; exp_q[u].push_back(e);
    for (int row = 0; row < r; row++) begin
      e = b; e.rd_en = 1'b1; e.rd_addr = {m_bank[u], 4'((row + 1) % r)}; exp_q[u].push_back(e);
      e = b; e.shift_en = 1'b1; exp_q[u].push_back(e);
      e = b; e.run = 1'b1; exp_q[u].push_back(e);
      e = b; e.wr_en = 1'b1; e.wr_addr = {~m_bank[u], 4'(row)}; exp_q[u].push_back(e);
    end
    e = b; e.gen_done = 1'b1; exp_q[u].push_back(e);
    m_bank[u] = ~m_bank[u];
    m_cnt[u]  = m_cnt[u] + 16'd1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unit
      localparam int R_I = (gi == 0) ? 16 : 3;
      logic        rd_en, shift_en, run, wr_en, busy, gen_done, bank;
      logic [4:0]  rd_addr, wr_addr;
      logic [15:0] gen_count;

      life_gen_sequencer #(.ROWS(R_I), .ROW_W(4), .GEN_W(16)) u_dut (
        .clk       (clk),
        .reset     (rst_s[gi]),
        .start     (start_s[gi]),
        .step      (step_s[gi]),
        .stop      (stop_s[gi]),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .shift_en  (shift_en),
        .run       (run),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .gen_done  (gen_done),
        .bank      (bank),
        .gen_count (gen_count)
      );

      // Monitor: one comparison per cycle, sampled just after the clock edge.
      initial begin
        rec_t        got;
        rec_t        exp_r;
        logic        was_rst;
        logic        idle_bank;
        logic [15:0] idle_cnt;
        idle_bank = 1'b0;
        idle_cnt  = '0;
        forever begin
          @(posedge clk);
          was_rst = rst_s[gi];
          #1;
          got          = '0;
          got.rd_en    = rd_en;
          got.rd_addr  = (rd_en === 1'b1) ? rd_addr : 5'd0;
          got.shift_en = shift_en;
          got.run      = run;
          got.wr_en    = wr_en;
          got.wr_addr  = (wr_en === 1'b1) ? wr_addr : 5'd0;
          got.gen_done = gen_done;
          got.busy     = busy;
          got.bank     = bank;
          got.cnt      = gen_count;
          if (was_rst) begin
            idle_bank = 1'b0;
            idle_cnt  = '0;
          end
          if (busy === 1'b1 || exp_q[gi].size() != 0) begin
            if (exp_q[gi].size() == 0) begin
              exp_r      = '0;
              exp_r.bank = idle_bank;
              exp_r.cnt  = idle_cnt;
            end else begin
              exp_r = exp_q[gi].pop_front();
              if (exp_r.gen_done) begin
                idle_bank = ~exp_r.bank;
                idle_cnt  = exp_r.cnt + 16'd1;
              end
            end
          end else begin
            exp_r      = '0;
            exp_r.bank = idle_bank;
            exp_r.cnt  = idle_cnt;
          end
          checks++;
          if (got !== exp_r) begin
            errors++;
            $display("FAIL unit%0d cycle_outputs t=%0t got=%h exp=%h", gi, $time, got, exp_r);
          end
        end
      end
    end
  endgenerate

  // kind: 0 = step, 1 = start, 2 = start+step. stop_j: busy cycle at which
  // stop is sampled (0 = together with the request, -1 = never).
  task automatic run_op(input int u, input int kind, input int n, input int stop_j, input bit junk);
    int l;
    l = 4 * rows_of(u) + 4;
    $display("op unit=%0d kind=%0d gens=%0d stop_at=%0d junk=%0d gen_count_before=%0d",
             u, kind, n, stop_j, junk, m_cnt[u]);
    @(negedge clk);
    start_s[u] = (kind != 0);
    step_s[u]  = (kind != 1);
    stop_s[u]  = (stop_j == 0);
    for (int g = 0; g < n; g++) push_gen(u);
    @(negedge clk);
    for (int j = 1; j <= n * l; j++) begin
      stop_s[u]  = (j == stop_j);
      start_s[u] = junk && ($urandom_range(0, 15) == 0);
      step_s[u]  = junk && ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    start_s[u] = 1'b0;
    step_s[u]  = 1'b0;
    stop_s[u]  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_mid(input int u, input int at);
    $display("op unit=%0d reset at busy cycle %0d", u, at);
    @(negedge clk);
    step_s[u] = 1'b1;
    push_gen(u);
    @(negedge clk);
    step_s[u] = 1'b0;
    repeat (at - 1) @(negedge clk);
    rst_s[u] = 1'b1;
    exp_q[u].delete();
    m_bank[u] = 1'b0;
    m_cnt[u]  = '0;
    @(negedge clk);
    rst_s[u] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int u;
    int kind;
    int n;
    int sj;
    int l;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 2; i++) begin
      rst_s[i]   = 1'b1;
      start_s[i] = 1'b0;
      step_s[i]  = 1'b0;
      stop_s[i]  = 1'b0;
      m_bank[i]  = 1'b0;
      m_cnt[i]   = '0;
    end
    repeat (3) @(negedge clk);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    repeat (20) @(negedge clk);

    run_op(0, 0, 1, -1, 1'b0);
    run_op(0, 1, 2, 100, 1'b0);
    run_op(1, 0, 1, -1, 1'b0);
    run_op(0, 2, 3, 2 * 68 + 40, 1'b1);
    run_op(0, 1, 1, 0, 1'b1);
    run_op(1, 1, 1, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      u    = $urandom_range(0, 1);
      l    = 4 * rows_of(u) + 4;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        n  = 1;
        sj = ($urandom_range(0, 1) == 1) ? $urandom_range(0, l) : -1;
      end else begin
        n  = $urandom_range(1, 3);
        sj = (n == 1 && $urandom_range(0, 1) == 1) ? 0 : (n - 1) * l + $urandom_range(1, l);
      end
      run_op(u, kind, n, sj, 1'b1);
    end

    reset_mid(0, 30);
    run_op(0, 0, 1, -1, 1'b0);
    reset_mid(1, 7);
    run_op(1, 0, 1, -1, 1'b0);

    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL unit%0d leftover_expected got_remaining=%0d exp=0", i, exp_q[i].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/life_gen_sequencer.md
# life_gen_sequencer

Generation-level scheduler for the Game of Life engine. It walks the cell memory row by row and streams a three-row window into the cell array. It strobes the array's compute phase and writes each new row into the opposite memory bank, then flips banks at the end of each generation. It sits between the host controls (start/step/stop) and the existing per-cell array and its phase controller, and owns all cell-memory addressing.

## Interface
- ROWS, 16, grid height in rows; legal range 3..2^ROW_W
- ROW_W, 4, row index width
- GEN_W, 16, generation counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  request continuous run; sampled only in IDLE
- step  in  1  request exactly one generation; sampled only in IDLE
- stop  in  1  request halt at the next generation boundary; sampled every non-IDLE cycle
- rd_en  out  1  cell-memory read strobe; fixed read latency of 1 cycle
- rd_addr  out  ROW_W+1  {bank, row} of the read
- shift_en  out  1  shift the read data into the array's 3-row window; data is valid this cycle
- run  out  1  one-cycle compute strobe to the cell array
- wr_en  out  1  cell-memory write strobe for the array's result row
- wr_addr  out  ROW_W+1  {~bank, row} of the write
- busy  out  1  high whenever state != IDLE
- gen_done  out  1  one-cycle pulse at the end of each generation
- bank  out  1  current source bank; the display reads this bank
- gen_count  out  GEN_W  completed generations; wraps to 0

## Operation
- States: IDLE, P0, P1, P2, RD, SH, RUN, WR, END. Registered row index r ranges 0..ROWS-1. Registered flags: cont (continuous mode) and stop_pend.
- IDLE: start → P0 with cont=1; step → P0 with cont=0; start and step together → start wins. If stop is high in the same cycle as start, stop_pend=1, giving a single generation.
- P0: rd_en, row ROWS-1.
- P1: shift_en, then rd_en row 0.
- P2: shift_en; r=0 → RD.
- RD: rd_en, row (r+1) mod ROWS. r=ROWS-1 reads row 0, giving the toroidal wrap.
- SH: shift_en. The window now holds rows r-1, r, r+1 (all mod ROWS).
- RUN: run=1.
- WR: wr_en, wr_addr={~bank,r}. If r==ROWS-1 → END; else r←r+1 → RD.
- END: gen_done=1. At exit, bank←~bank and gen_count←gen_count+1. If cont && !stop_pend && !stop → P0; else → IDLE, clearing cont and stop_pend.
- stop seen in any non-IDLE state sets stop_pend. A generation is never aborted by stop.
- start and step while busy are ignored, with no queuing.
- Exactly one of rd_en/shift_en/run/wr_en is high per cycle, except P1, where shift_en and rd_en are both high. All strobes are 0 in IDLE and END.
- Address arithmetic is modulo ROWS, not 2^ROW_W. Row indices never exceed ROWS-1.

## Timing
- Reset: state=IDLE, r=0, bank=0, gen_count=0, cont=0, stop_pend=0. All strobes, busy and gen_done are 0 in the cycle after reset is sampled.
- Reset mid-generation aborts immediately. The partially written bank is left as-is and bank returns to 0.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Latency from start/step high in IDLE: P0 in the next cycle, with busy high.
- Generation length: 3 + 4·ROWS + 1 = 4·ROWS+4 cycles, which is 68 for ROWS=16.
- In continuous mode, END is followed directly by P0, so generations are back-to-back with no idle gap.
- Read data for the rd_en issued in cycle T is consumed by shift_en in cycle T+1.

## Test plan
- Reset, then hold all inputs low for 20 cycles → all outputs 0, bank=0, gen_count=0.
- ROWS=16, step pulse → busy for exactly 68 cycles. rd rows: 15,0,1,2,…,15,0. wr_addr {1,0}…{1,15}. gen_done pulses once in the final busy cycle. Afterwards bank=1 and gen_count=1.
- ROWS=16, start then stop at cycle 100 → the second generation completes; idle at cycle 137; gen_count=2; bank=0; no third P0.
- ROWS=3, step → rd rows 2,0,1,2,0; wr rows 0,1,2 to bank 1; busy for 16 cycles.
- Step, then assert reset at busy cycle 30 → next cycle state is IDLE, all strobes 0, gen_count=0, bank=0. A following step runs a full 68-cycle generation.
- start+step in the same IDLE cycle → continuous run, at least 3 generations. step during busy → no effect on sequence or count. start+stop in the same cycle → exactly 1 generation.
